// File: rtl/bcd_mul_seq_pkg.sv
// bcd_pkg: shared definitions for the sequential BCD multiplier.
//   BCD_DIGIT_W  - bits per packed BCD digit
//   BCD_NINE     - largest legal BCD digit value
//   state_t      - controller states S_IDLE / S_ADD / S_DONE (2-bit encoding)
//   is_bcd_digit - returns 1 when a nibble holds a legal decimal digit
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE    = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return (d <= BCD_NINE);
    endfunction

endpackage

// File: rtl/bcd_mul_seq_if.sv
// bcd_mul_seq_if: launch/operand/result bundle between the calculator
// controller (master) and the BCD multiplier (slave).
//   start   - one-cycle launch pulse (master -> slave)
//   a_bcd   - multiplicand, packed BCD, digit 0 in [3:0]
//   b_bcd   - multiplier, packed BCD
//   product - packed BCD product, 2*DIGITS digits
//   busy    - multiplier is not idle
//   done    - one-cycle pulse, product valid
//   invalid - an operand of the last accepted start held a digit > 9
interface bcd_mul_seq_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic [4*DIGITS-1:0]   a_bcd;
    logic [4*DIGITS-1:0]   b_bcd;
    logic [8*DIGITS-1:0]   product;
    logic                  busy;
    logic                  done;
    logic                  invalid;

    modport master (
        output start, a_bcd, b_bcd,
        input  product, busy, done, invalid
    );

    modport slave (
        input  start, a_bcd, b_bcd,
        output product, busy, done, invalid
    );
endinterface

// File: rtl/bcd_mul_seq_digit_add.sv
// bcd_digit_add: one decimal digit of a BCD ripple adder.
//   a, b - BCD digits (0..9)
//   cin  - carry from the next lower digit
//   s    - BCD sum digit
//   cout - decimal carry to the next higher digit
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] binSum;

    always_comb begin
        binSum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (binSum > {1'b0, BCD_NINE}) begin
            // Skip the six unused codes 10..15; the 4-bit wrap drops the 16.
            s    = binSum[3:0] + 4'd6;
            cout = 1'b1;
        end else begin
            s    = binSum[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_mul_seq.sv
// bcd_mul_seq: sequential BCD multiplier by repeated addition.
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - bcd_mul_seq_if.slave (start, a_bcd, b_bcd in; product, busy,
//          done, invalid out)
// A start in S_IDLE latches the operands; S_ADD adds the multiplicand into
// the accumulator once per cycle while counting the multiplier down to 0.
// Build option: define BCD_MUL_SWAP_EN to count down the smaller operand
// instead of always the multiplier (same products, shorter latency).
module bcd_mul_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    bcd_mul_seq_if.slave  bus
);

    localparam int OPW  = BCD_DIGIT_W * DIGITS;
    localparam int PW   = 2 * OPW;
    localparam int NACC = 2 * DIGITS;
    localparam logic [OPW-1:0] CNT_ONE = OPW'(1);

    state_t          stateReg,   stateNext;
    logic [PW-1:0]   accReg,     accNext;
    logic [OPW-1:0]  cntReg,     cntNext;
    logic [OPW-1:0]  opaReg,     opaNext;
    logic [PW-1:0]   productReg, productNext;
    logic            invalidReg, invalidNext;

    logic [PW-1:0]   opaExt;
    logic [PW-1:0]   accSum;
    logic [OPW-1:0]  cntDec;
    logic [DIGITS-1:0] digitOk;
    logic            opsValid;
    logic [OPW-1:0]  loadOpa;
    logic [OPW-1:0]  loadCnt;

    assign opaExt = {{OPW{1'b0}}, opaReg};

    // Accumulator adder: each stage reads the previous stage's carry by
    // name so every carry is its own net.
    for (genvar gi = 0; gi < NACC; gi++) begin : genAdd
        logic cin;
        logic cout;
        if (gi == 0) begin : genFirst
            assign cin = 1'b0;
        end else begin : genRest
            assign cin = genAdd[gi-1].cout;
        end
        bcd_digit_add uAdd (
            .a    (accReg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .b    (opaExt[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cin  (cin),
            .s    (accSum[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout (cout)
        );
    end

    // Counter decrement: a borrow into a 0 digit yields 9 and keeps borrowing.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : genDec
        logic       bin;
        logic       bout;
        logic [3:0] digit;
        if (gi == 0) begin : genFirst
            assign bin = 1'b1;
        end else begin : genRest
            assign bin = genDec[gi-1].bout;
        end
        assign digit = cntReg[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
        always_comb begin
            bout = 1'b0;
            cntDec[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = digit;
            if (bin) begin
                if (digit == 4'd0) begin
                    cntDec[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_NINE;
                    bout = 1'b1;
                end else begin
                    cntDec[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = digit - 4'd1;
                end
            end
        end
    end

    // The top carry and top borrow can never fire (no overflow; the
    // counter is never decremented from 0), so they are dropped here.
    logic unusedTopChain;
    assign unusedTopChain = genAdd[NACC-1].cout ^ genDec[DIGITS-1].bout;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : genValid
        assign digitOk[gi] = is_bcd_digit(bus.a_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
                           && is_bcd_digit(bus.b_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    assign opsValid = &digitOk;

`ifdef BCD_MUL_SWAP_EN
    // Packed BCD compares like decimal, so a plain unsigned compare works.
    always_comb begin
        if (bus.a_bcd < bus.b_bcd) begin
            loadOpa = bus.b_bcd;
            loadCnt = bus.a_bcd;
        end else begin
            loadOpa = bus.a_bcd;
            loadCnt = bus.b_bcd;
        end
    end
`else
    assign loadOpa = bus.a_bcd;
    assign loadCnt = bus.b_bcd;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg   <= S_IDLE;
            accReg     <= '0;
            cntReg     <= '0;
            opaReg     <= '0;
            productReg <= '0;
            invalidReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            accReg     <= accNext;
            cntReg     <= cntNext;
            opaReg     <= opaNext;
            productReg <= productNext;
            invalidReg <= invalidNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        accNext     = accReg;
        cntNext     = cntReg;
        opaNext     = opaReg;
        productNext = productReg;
        invalidNext = invalidReg;
        case (stateReg)
            S_IDLE: begin
                if (bus.start) begin
                    accNext     = '0;
                    productNext = '0;
                    invalidNext = 1'b0;
                    opaNext     = loadOpa;
                    cntNext     = loadCnt;
                    if (!opsValid) begin
                        invalidNext = 1'b1;
                        stateNext   = S_DONE;
                    end else if (bus.a_bcd == '0 || bus.b_bcd == '0) begin
                        stateNext   = S_DONE;
                    end else begin
                        stateNext   = S_ADD;
                    end
                end
            end
            S_ADD: begin
                accNext = accSum;
                cntNext = cntDec;
                if (cntReg == CNT_ONE) begin
                    // Last addition: publish the finished sum as we enter S_DONE.
                    productNext = accSum;
                    stateNext   = S_DONE;
                end
            end
            S_DONE: begin
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    assign bus.product = productReg;
    assign bus.busy    = (stateReg != S_IDLE);
    assign bus.done    = (stateReg == S_DONE);
    assign bus.invalid = invalidReg;

endmodule

// File: tb/tb_bcd_mul_seq.sv
// tb_bcd_mul_seq: self-checking bench for bcd_mul_seq (DIGITS=2).
// A decimal-arithmetic model predicts busy/done/product/invalid on every
// cycle; directed operations pin the model with literal results.
module tb_bcd_mul_seq;

    logic clk = 1'b0;
    logic rst;

    bcd_mul_seq_if #(.DIGITS(2)) bus ();

    bcd_mul_seq #(.DIGITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    function automatic bit bcdOk(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
    endfunction

    function automatic int bcdVal(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] toBcd(input int n);
        logic [15:0] r;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[15:12] = 4'((n / 1000) % 10);
        return r;
    endfunction

    // Expected product of one operation (0 when an operand is malformed).
    function automatic logic [15:0] modelProduct(input logic [7:0] a, input logic [7:0] b);
        if (!(bcdOk(a) && bcdOk(b))) return 16'h0000;
        return toBcd(bcdVal(a) * bcdVal(b));
    endfunction

    // Cycle (counted from the accepting edge) in which done must pulse.
    function automatic int modelLatency(input logic [7:0] a, input logic [7:0] b);
        int av;
        int bv;
        if (!(bcdOk(a) && bcdOk(b))) return 1;
        av = bcdVal(a);
        bv = bcdVal(b);
        if (av == 0 || bv == 0) return 1;
`ifdef BCD_MUL_SWAP_EN
        return ((av < bv) ? av : bv) + 1;
`else
        return bv + 1;
`endif
    endfunction

    // Model state: cycles left in the current operation and expected outputs.
    int          rem      = 0;
    logic [15:0] expProd  = 16'h0000;
    logic [15:0] finProd  = 16'h0000;
    logic        expInv   = 1'b0;

    initial begin : compare
        @(posedge clk);
        forever begin
            if (!rst) begin
                rem     = 0;
                expProd = 16'h0000;
                expInv  = 1'b0;
            end else if (rem > 0) begin
                rem--;
                if (rem == 1) expProd = finProd;
            end else if (bus.start) begin
                rem     = modelLatency(bus.a_bcd, bus.b_bcd);
                finProd = modelProduct(bus.a_bcd, bus.b_bcd);
                expInv  = !(bcdOk(bus.a_bcd) && bcdOk(bus.b_bcd));
                expProd = (rem == 1) ? finProd : 16'h0000;
            end
            #1;
            check("cyc_busy",    {31'b0, bus.busy},    {31'b0, rem > 0});
            check("cyc_done",    {31'b0, bus.done},    {31'b0, rem == 1});
            check("cyc_product", {16'b0, bus.product}, {16'b0, expProd});
            check("cyc_invalid", {31'b0, bus.invalid}, {31'b0, expInv});
            @(posedge clk);
        end
    end

    // Launch one operation (inputs change 1 time unit after rising edges).
    // p1/p2: extra start pulses in those cycles; rstAt: pull rst low in that
    // cycle and return in the following one. Otherwise returns in the idle
    // cycle right after done.
    task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                         input int p1, input int p2, input int rstAt,
                         output int doneAt, output int doneCnt,
                         output logic [15:0] prod, output logic inv);
        int n;
        doneAt  = -1;
        doneCnt = 0;
        prod    = 16'h0000;
        inv     = 1'b0;
        bus.start = 1'b1;
        bus.a_bcd = a;
        bus.b_bcd = b;
        @(posedge clk);
        #1;
        n = 1;
        bus.a_bcd = 8'($urandom);
        bus.b_bcd = 8'($urandom);
        while (1'b1) begin
            if (bus.done) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt = n;
                    prod   = bus.product;
                    inv    = bus.invalid;
                end
            end
            bus.start = 1'b0;
            if (doneAt > 0 && n > doneAt) break;
            if (rstAt > 0 && n == rstAt + 1) begin
                rst = 1'b1;
                break;
            end
            if (n > 250) break;
            rst = (n == rstAt) ? 1'b0 : 1'b1;
            if (n == p1 || n == p2) begin
                bus.start = 1'b1;
                bus.a_bcd = 8'($urandom);
                bus.b_bcd = 8'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (rstAt < 0) check("done_seen", {31'b0, doneAt >= 0}, 32'd1);
    endtask

    int          dAt;
    int          dCnt;
    logic [15:0] prod;
    logic        inv;
    logic [7:0]  ra;
    logic [7:0]  rb;

    initial begin : stimulus
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a_bcd = 8'h00;
        bus.b_bcd = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("reset_busy",    {31'b0, bus.busy},    32'd0);
        check("reset_done",    {31'b0, bus.done},    32'd0);
        check("reset_product", {16'b0, bus.product}, 32'd0);
        check("reset_invalid", {31'b0, bus.invalid}, 32'd0);

        runOp(8'h12, 8'h34, -1, -1, -1, dAt, dCnt, prod, inv);
        $display("op 12*34: done cycle %0d product %h invalid %0b", dAt, prod, inv);
        check("t1_done_cycle", dAt, 35);
        check("t1_done_count", dCnt, 1);
        check("t1_product", {16'b0, prod}, 32'h0408);
        check("t1_invalid", {31'b0, inv}, 32'd0);

        runOp(8'h99, 8'h99, -1, -1, -1, dAt, dCnt, prod, inv);
        $display("op 99*99: done cycle %0d product %h", dAt, prod);
        check("t2_done_cycle", dAt, 100);
        check("t2_product", {16'b0, prod}, 32'h9801);

        runOp(8'h57, 8'h00, -1, -1, -1, dAt, dCnt, prod, inv);
        $display("op 57*00: done cycle %0d product %h", dAt, prod);
        check("t3_done_cycle", dAt, 1);
        check("t3_product", {16'b0, prod}, 32'h0000);

        runOp(8'h00, 8'h45, -1, -1, -1, dAt, dCnt, prod, inv);
        $display("op 00*45: done cycle %0d product %h", dAt, prod);
        check("t4_done_cycle", dAt, 1);
        check("t4_product", {16'b0, prod}, 32'h0000);

        runOp(8'h1A, 8'h05, -1, -1, -1, dAt, dCnt, prod, inv);
        $display("op 1A*05: done cycle %0d product %h invalid %0b", dAt, prod, inv);
        check("t5_done_cycle", dAt, 1);
        check("t5_invalid", {31'b0, inv}, 32'd1);
        check("t5_product", {16'b0, prod}, 32'h0000);

        runOp(8'h02, 8'h03, -1, -1, -1, dAt, dCnt, prod, inv);
        $display("op 02*03: done cycle %0d product %h invalid %0b", dAt, prod, inv);
        check("t5b_invalid_cleared", {31'b0, inv}, 32'd0);
        check("t5b_product", {16'b0, prod}, 32'h0006);
        check("t5b_done_cycle", dAt, 4);

        runOp(8'h03, 8'h20, 5, 21, -1, dAt, dCnt, prod, inv);
        $display("op 03*20 extra starts: done cycle %0d count %0d product %h", dAt, dCnt, prod);
        check("t6_done_cycle", dAt, 21);
        check("t6_done_count", dCnt, 1);
        check("t6_product", {16'b0, prod}, 32'h0060);

        runOp(8'h25, 8'h40, -1, -1, 10, dAt, dCnt, prod, inv);
        $display("op 25*40 reset at 10: done count %0d busy %0b product %h", dCnt, bus.busy, bus.product);
        check("t7_done_count", dCnt, 0);
        check("t7_busy", {31'b0, bus.busy}, 32'd0);
        check("t7_product", {16'b0, bus.product}, 32'h0000);

        runOp(8'h99, 8'h03, -1, -1, -1, dAt, dCnt, prod, inv);
        $display("op 99*03: done cycle %0d product %h", dAt, prod);
        check("t8_done_cycle", dAt, 4);
        check("t8_product", {16'b0, prod}, 32'h0297);

        runOp(8'h03, 8'h99, -1, -1, -1, dAt, dCnt, prod, inv);
        $display("op 03*99: done cycle %0d product %h", dAt, prod);
`ifdef BCD_MUL_SWAP_EN
        check("t9_done_cycle", dAt, 4);
`else
        check("t9_done_cycle", dAt, 100);
`endif
        check("t9_product", {16'b0, prod}, 32'h0297);

        for (int i = 0; i < 25; i++) begin
            ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 7) == 0) ra[3:0] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rb[7:4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) rb = 8'h00;
            runOp(ra, rb, -1, -1, -1, dAt, dCnt, prod, inv);
            $display("op %h*%h: done cycle %0d product %h invalid %0b", ra, rb, dAt, prod, inv);
            check("rand_done_cycle", dAt, modelLatency(ra, rb));
            check("rand_product", {16'b0, prod}, {16'b0, modelProduct(ra, rb)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
